// File: rtl/program_loader_if.sv
// Memory port B write bus between the boot loader and instruction memory.
interface program_loader_if #(
  parameter int ADDR_W = 10
);
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_data;

  modport master (output mem_we, output mem_addr, output mem_data);
  modport slave  (input  mem_we, input  mem_addr, input  mem_data);
endinterface

// File: rtl/program_loader.sv
// Serial boot loader: 8N1 UART receiver, byte-to-word assembler and load FSM.
// Image format: 16-bit big-endian word count, then that many big-endian words.
// The CPU is held in reset until the whole image has been written.
module program_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx,
  program_loader_if.master  mem,
  output logic              cpu_reset,
  output logic              done,
  output logic              err,
  output logic              overflow
);

  localparam int          CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {LEN_HI, LEN_LO, DATA_HI, DATA_LO, DONE, ERROR} ld_state_t;

  // Receiver state
  logic             r_rx_meta;
  logic             r_rx_sync;
  rx_state_t        r_rx_state;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_byte_valid;
  logic             r_frame_err;

  // Loader state
  ld_state_t         r_ld_state;
  logic [15:0]       r_len;
  logic [7:0]        r_hi;
  logic [16:0]       r_word_cnt;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [15:0]       r_mem_data;
  logic              r_cpu_reset;
  logic              r_done;
  logic              r_err;
  logic              r_overflow;

  logic [15:0] w_len_full;
  logic [16:0] w_word_next;

  assign w_len_full  = {r_len[15:8], r_shift};
  assign w_word_next = r_word_cnt + 17'd1;

  // Two-flop synchroniser; the raw line is never used anywhere else.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // 8N1 receiver: mid-bit sampling, glitch-rejecting start check, stop-bit framing check.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rx_state   <= RX_IDLE;
      r_clk_cnt    <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          r_clk_cnt <= '0;
          if (!r_rx_sync) r_rx_state <= RX_START;
        end
        RX_START: begin
          if (r_clk_cnt == HALF_LAST) begin
            r_clk_cnt  <= '0;
            r_bit_idx  <= '0;
            r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_clk_cnt == FULL_LAST) begin
            r_clk_cnt <= '0;
            r_shift   <= {r_rx_sync, r_shift[7:1]};
            if (r_bit_idx == 3'd7) r_rx_state <= RX_STOP;
            else                   r_bit_idx  <= r_bit_idx + 1'b1;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_clk_cnt == FULL_LAST) begin
            r_clk_cnt  <= '0;
            r_rx_state <= RX_IDLE;
            if (r_rx_sync) r_byte_valid <= 1'b1;
            else           r_frame_err  <= 1'b1;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // Load FSM: header, word assembly, gated memory writes and CPU reset release.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ld_state  <= LEN_HI;
      r_len       <= '0;
      r_hi        <= '0;
      r_word_cnt  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
      r_cpu_reset <= 1'b1;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      if (r_ld_state == DONE) begin
        r_done      <= 1'b1;
        r_cpu_reset <= 1'b0;
      end
      if (r_frame_err && (r_ld_state == LEN_HI || r_ld_state == LEN_LO ||
                          r_ld_state == DATA_HI || r_ld_state == DATA_LO)) begin
        r_ld_state <= ERROR;
        r_err      <= 1'b1;
      end else if (r_byte_valid) begin
        case (r_ld_state)
          LEN_HI: begin
            r_len[15:8] <= r_shift;
            r_ld_state  <= LEN_LO;
          end
          LEN_LO: begin
            r_len <= w_len_full;
            if (w_len_full == 16'd0) begin
              r_ld_state <= DONE;
            end else begin
              if ({1'b0, w_len_full} > DEPTH) r_overflow <= 1'b1;
              r_ld_state <= DATA_HI;
            end
          end
          DATA_HI: begin
            r_hi       <= r_shift;
            r_ld_state <= DATA_LO;
          end
          DATA_LO: begin
            // Words past the memory depth are consumed but never written.
            if (r_word_cnt < DEPTH) begin
              r_mem_we   <= 1'b1;
              r_mem_addr <= r_word_cnt[ADDR_W-1:0];
              r_mem_data <= {r_hi, r_shift};
            end
            r_word_cnt <= w_word_next;
            r_ld_state <= (w_word_next == {1'b0, r_len}) ? DONE : DATA_HI;
          end
          default: ;
        endcase
      end
    end
  end

  assign mem.mem_we   = r_mem_we;
  assign mem.mem_addr = r_mem_addr;
  assign mem.mem_data = r_mem_data;
  assign cpu_reset    = r_cpu_reset;
  assign done         = r_done;
  assign err          = r_err;
  assign overflow     = r_overflow;

endmodule
